// File: rtl/debug_uart_pkg.sv
// Shared types, frame constants and divider helper for the debug UART transmitter.
package debug_uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_tx_state_t;

  localparam int unsigned UART_DATA_BITS  = 8;
  localparam int unsigned UART_FRAME_BITS = 10;

  function automatic int unsigned uart_div(input int unsigned clk_hz, input int unsigned bit_rate);
    return clk_hz / bit_rate;
  endfunction

endpackage

// File: rtl/debug_uart_tx_fifo_byte_fifo.sv
// Byte FIFO with registered level/full; push while full is dropped, pointers wrap by width.
module byte_fifo #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [7:0]               push_data,
  input  logic                     pop,
  output logic [7:0]               pop_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned LW = $clog2(DEPTH) + 1;

  logic [7:0]    mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [LW-1:0] level_q, level_d;
  logic          full_q;
  logic          do_push, do_pop;

  assign do_push = push & ~full_q;
  assign do_pop  = pop & (level_q != '0);

  always_comb begin
    level_d = level_q;
    if (do_push && !do_pop) begin
      level_d = level_q + LW'(1);
    end else if (!do_push && do_pop) begin
      level_d = level_q - LW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      full_q   <= 1'b0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      level_q <= level_d;
      full_q  <= (level_d == LW'(DEPTH));
    end
  end

  // Storage needs no reset: the pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

  assign pop_data = mem_q[rd_ptr_q];
  assign level    = level_q;
  assign full     = full_q;
  assign empty    = (level_q == '0);

endmodule

// File: rtl/debug_uart_tx_fifo.sv
// Debug UART transmitter: byte FIFO drained by an 8N1 serialiser onto txd.
// Optional done interrupt enabled by defining DEBUG_UART_DONE_IRQ_EN.
module debug_uart_tx_fifo
  import debug_uart_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 64_000_000,
  parameter int unsigned BIT_RATE   = 4_000_000,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          wr_en,
  input  logic [7:0]                    wr_data,
  output logic                          txd,
  output logic                          busy,
  output logic                          fifo_full,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          overflow
`ifdef DEBUG_UART_DONE_IRQ_EN
  ,
  output logic                          done_irq
`endif
);

  localparam int unsigned DIV = uart_div(CLK_HZ, BIT_RATE);
  localparam int unsigned BW  = $clog2(DIV);
  localparam int unsigned IW  = $clog2(UART_DATA_BITS);

  if (DIV < 2) begin : g_div_check
    $error("debug_uart_tx_fifo: CLK_HZ/BIT_RATE must be at least 2");
  end
  if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_depth_check
    $error("debug_uart_tx_fifo: FIFO_DEPTH must be a power of two and >= 2");
  end
  if (UART_FRAME_BITS != UART_DATA_BITS + 2) begin : g_frame_check
    $error("debug_uart_tx_fifo: frame must be start + data + one stop bit");
  end

  uart_tx_state_t state_q, state_d;
  logic [BW-1:0]  baud_q, baud_d;
  logic [IW-1:0]  bit_q, bit_d;
  logic [7:0]     shift_q, shift_d;
  logic           txd_q, txd_d;
  logic           ovf_q;
  logic           bit_end_c;
  logic           pop_c;
  logic [7:0]     head;
  logic           fifo_full_w, fifo_empty_w;

  byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (wr_en),
    .push_data (wr_data),
    .pop       (pop_c),
    .pop_data  (head),
    .level     (level),
    .full      (fifo_full_w),
    .empty     (fifo_empty_w)
  );

  assign bit_end_c = (baud_q == BW'(DIV - 1));

  // Shifter next state; txd is registered from the next state so it moves with the FSM.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    pop_c   = 1'b0;
    if (state_q != IDLE) baud_d = bit_end_c ? '0 : baud_q + BW'(1);
    case (state_q)
      IDLE: begin
        if (!fifo_empty_w) begin
          pop_c   = 1'b1;
          shift_d = head;
          baud_d  = '0;
          state_d = START;
        end
      end
      START: begin
        if (bit_end_c) begin
          bit_d   = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        if (bit_end_c) begin
          if (bit_q == IW'(UART_DATA_BITS - 1)) begin
            state_d = STOP;
          end else begin
            shift_d = shift_q >> 1;
            bit_d   = bit_q + IW'(1);
          end
        end
      end
      STOP: begin
        if (bit_end_c) begin
          if (!fifo_empty_w) begin
            pop_c   = 1'b1;
            shift_d = head;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    case (state_d)
      START:   txd_d = 1'b0;
      DATA:    txd_d = shift_d[0];
      default: txd_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      txd_q   <= 1'b1;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      txd_q   <= txd_d;
      if (wr_en && fifo_full_w) ovf_q <= 1'b1;
    end
  end

`ifdef DEBUG_UART_DONE_IRQ_EN
  logic done_q, done_d;

  // Set when the last frame ends with nothing queued; an accepted push clears it.
  always_comb begin
    done_d = done_q;
    if (state_q == STOP && bit_end_c && fifo_empty_w) done_d = 1'b1;
    if (wr_en && !fifo_full_w) done_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) done_q <= 1'b0;
    else        done_q <= done_d;
  end

  assign done_irq = done_q;
`endif

  assign txd       = txd_q;
  assign busy      = (state_q != IDLE) | ~fifo_empty_w;
  assign fifo_full = fifo_full_w;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_debug_uart_tx_fifo.sv
// Directed self-checking bench for debug_uart_tx_fifo at default parameters.
module tb_debug_uart_tx_fifo;
  import debug_uart_pkg::*;

  localparam int unsigned DIV   = 16;
  localparam int unsigned FRAME = DIV * UART_FRAME_BITS;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       txd, busy, fifo_full, overflow;
  logic [2:0] level;
`ifdef DEBUG_UART_DONE_IRQ_EN
  logic       done_irq;
`endif

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  logic [7:0] rx_q[$];
  int         rx_start[$];
  logic       rx_stop[$];

  debug_uart_tx_fifo dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .txd       (txd),
    .busy      (busy),
    .fifo_full (fifo_full),
    .level     (level),
    .overflow  (overflow)
`ifdef DEBUG_UART_DONE_IRQ_EN
    ,
    .done_irq  (done_irq)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Line receiver: samples each bit mid-period, logs byte, start cycle and stop bit
  initial begin : rx_proc
    logic [7:0] b;
    logic       s;
    int         t0;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && txd === 1'b0) begin
        t0 = cyc;
        repeat (DIV / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (DIV) @(negedge clk);
          b[i] = txd;
        end
        repeat (DIV) @(negedge clk);
        s = txd;
        rx_q.push_back(b);
        rx_start.push_back(t0);
        rx_stop.push_back(s);
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

  task automatic clear_rx();
    rx_q.delete();
    rx_start.delete();
    rx_stop.delete();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] b);
    wr_en   = 1'b1;
    wr_data = b;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
  endtask

  task automatic wait_idle(input int limit, output int t_end, output bit ok);
    ok    = 1'b0;
    t_end = 0;
    for (int i = 0; i < limit; i++) begin
      @(posedge clk);
      #1;
      if (busy === 1'b0) begin
        ok    = 1'b1;
        t_end = cyc;
        break;
      end
    end
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    checks++; if (txd !== 1'b1) begin errors++; $display("FAIL reset_txd: got %b want 1", txd); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (fifo_full !== 1'b0) begin errors++; $display("FAIL reset_full: got %b want 0", fifo_full); end
    checks++; if (level !== 3'd0) begin errors++; $display("FAIL reset_level: got %0d want 0", level); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b want 0", overflow); end
`ifdef DEBUG_UART_DONE_IRQ_EN
    checks++; if (done_irq !== 1'b0) begin errors++; $display("FAIL reset_done_irq: got %b want 0", done_irq); end
`endif
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (txd !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL reset_idle: txd=%b busy=%b want 1/0", txd, busy); end
  endtask

  task automatic test_single();
    logic [9:0] seq;
    int         t_fall, bad;
    seq = {1'b1, 8'hA5, 1'b0};
    do_reset();
    clear_rx();
    push(8'hA5);
    checks++; if (level !== 3'd1) begin errors++; $display("FAIL single_level_e0: got %0d want 1", level); end
    checks++; if (txd !== 1'b1) begin errors++; $display("FAIL single_txd_e0: got %b want 1", txd); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy_e0: got %b want 1", busy); end
    @(posedge clk);
    #1;
    t_fall = cyc;
    checks++; if (txd !== 1'b0) begin errors++; $display("FAIL single_txd_e1: got %b want 0", txd); end
    checks++; if (level !== 3'd0) begin errors++; $display("FAIL single_level_e1: got %0d want 0", level); end
    for (int k = 0; k < 10; k++) begin
      bad = 0;
      for (int c = 0; c < int'(DIV); c++) begin
        if (txd !== seq[k] || busy !== 1'b1) bad++;
        @(posedge clk);
        #1;
      end
      checks++;
      if (bad != 0) begin errors++; $display("FAIL single_bit%0d: %0d wrong cycles want txd=%b for %0d cycles", k, bad, seq[k], DIV); end
    end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_drop: got %b want 0", busy); end
    checks++; if (cyc - t_fall != int'(FRAME)) begin errors++; $display("FAIL single_frame_len: got %0d want %0d", cyc - t_fall, FRAME); end
    checks++; if (rx_q.size() != 1 || rx_q[0] !== 8'hA5) begin errors++; $display("FAIL single_rx: got %0d bytes first %h want 1 byte a5", rx_q.size(), (rx_q.size() > 0) ? rx_q[0] : 8'hxx); end
  endtask

  task automatic test_burst();
    int max_lvl, t_end, bad;
    bit full_seen, ok;
    do_reset();
    clear_rx();
    max_lvl   = 0;
    full_seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      push(8'(i + 1));
      if (int'(level) > max_lvl) max_lvl = int'(level);
      if (fifo_full === 1'b1) full_seen = 1'b1;
    end
    wait_idle(1000, t_end, ok);
    checks++; if (max_lvl != 3) begin errors++; $display("FAIL burst_level_peak: got %0d want 3", max_lvl); end
    checks++; if (full_seen) begin errors++; $display("FAIL burst_full: got 1 want 0"); end
    checks++; if (!ok) begin errors++; $display("FAIL burst_timeout: busy stuck got 1 want 0"); end
    checks++; if (rx_q.size() != 4) begin errors++; $display("FAIL burst_count: got %0d want 4", rx_q.size()); end
    if (rx_q.size() == 4) begin
      bad = 0;
      for (int i = 0; i < 4; i++) begin
        if (rx_q[i] !== 8'(i + 1) || rx_stop[i] !== 1'b1) bad++;
        if (i > 0 && rx_start[i] - rx_start[i-1] != int'(FRAME)) bad++;
      end
      checks++; if (bad != 0) begin errors++; $display("FAIL burst_frames: %0d bad bytes/gaps want 01..04 contiguous", bad); end
      checks++; if (t_end - rx_start[0] != 4 * int'(FRAME)) begin errors++; $display("FAIL burst_total: got %0d want %0d", t_end - rx_start[0], 4 * FRAME); end
    end
  endtask

  task automatic test_overflow();
    int t_end, bad;
    bit ok;
    do_reset();
    clear_rx();
    for (int i = 0; i < 6; i++) begin
      push(8'(8'h10 + i));
      if (i == 3) begin
        checks++; if (fifo_full !== 1'b0) begin errors++; $display("FAIL ovf_full_4th: got %b want 0", fifo_full); end
      end
      if (i == 4) begin
        checks++; if (fifo_full !== 1'b1) begin errors++; $display("FAIL ovf_full_5th: got %b want 1", fifo_full); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_early: got %b want 0", overflow); end
      end
      if (i == 5) begin
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b want 1", overflow); end
        checks++; if (level !== 3'd4) begin errors++; $display("FAIL ovf_level: got %0d want 4", level); end
      end
    end
    wait_idle(1200, t_end, ok);
    checks++; if (!ok) begin errors++; $display("FAIL ovf_timeout: busy stuck got 1 want 0"); end
    checks++; if (rx_q.size() != 5) begin errors++; $display("FAIL ovf_count: got %0d want 5", rx_q.size()); end
    if (rx_q.size() == 5) begin
      bad = 0;
      for (int i = 0; i < 5; i++) if (rx_q[i] !== 8'(8'h10 + i) || rx_stop[i] !== 1'b1) bad++;
      checks++; if (bad != 0) begin errors++; $display("FAIL ovf_order: %0d bad bytes want 10..14", bad); end
    end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b want 1", overflow); end
  endtask

  // Runs without reset so the pointers start mid-array and wrap
  task automatic test_wrap();
    int t_end, bad;
    bit ok;
    clear_rx();
    push(8'hC1);
    push(8'hC2);
    push(8'hC3);
    checks++; if (level !== 3'd2) begin errors++; $display("FAIL wrap_level_pre: got %0d want 2", level); end
    repeat (158) @(posedge clk);
    #1;
    checks++; if (level !== 3'd2 || txd !== 1'b1) begin errors++; $display("FAIL wrap_stop_state: level=%0d txd=%b want 2/1", level, txd); end
    push(8'hC4);
    checks++; if (level !== 3'd2) begin errors++; $display("FAIL wrap_level_same: got %0d want 2", level); end
    checks++; if (txd !== 1'b0) begin errors++; $display("FAIL wrap_next_start: got %b want 0", txd); end
    wait_idle(800, t_end, ok);
    checks++; if (!ok) begin errors++; $display("FAIL wrap_timeout: busy stuck got 1 want 0"); end
    checks++; if (rx_q.size() != 4) begin errors++; $display("FAIL wrap_count: got %0d want 4", rx_q.size()); end
    if (rx_q.size() == 4) begin
      bad = 0;
      for (int i = 0; i < 4; i++) if (rx_q[i] !== 8'(8'hC1 + i)) bad++;
      checks++; if (bad != 0) begin errors++; $display("FAIL wrap_order: %0d bad bytes want c1..c4", bad); end
      checks++; if (rx_start[1] - rx_start[0] != int'(FRAME)) begin errors++; $display("FAIL wrap_gap: got %0d want %0d", rx_start[1] - rx_start[0], FRAME); end
    end
  endtask

  task automatic test_reset_mid();
    int lows;
    do_reset();
    clear_rx();
    push(8'h00);
    push(8'h00);
    repeat (50) @(posedge clk);
    #1;
    checks++; if (txd !== 1'b0 || level !== 3'd1) begin errors++; $display("FAIL rstmid_pre: txd=%b level=%0d want 0/1", txd, level); end
    rst_n = 1'b0;
    #1;
    checks++; if (txd !== 1'b1) begin errors++; $display("FAIL rstmid_txd: got %b want 1", txd); end
    checks++; if (level !== 3'd0 || busy !== 1'b0) begin errors++; $display("FAIL rstmid_state: level=%0d busy=%b want 0/0", level, busy); end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    lows = 0;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk);
      #1;
      if (txd !== 1'b1 || busy !== 1'b0) lows++;
    end
    checks++; if (lows != 0) begin errors++; $display("FAIL rstmid_quiet: got %0d active cycles want 0", lows); end
  endtask

`ifdef DEBUG_UART_DONE_IRQ_EN
  task automatic test_done_irq();
    int early, t_end;
    bit ok;
    do_reset();
    clear_rx();
    push(8'h5A);
    push(8'h3C);
    checks++; if (done_irq !== 1'b0) begin errors++; $display("FAIL irq_initial: got %b want 0", done_irq); end
    early = 0;
    ok    = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk);
      #1;
      if (busy === 1'b0) begin ok = 1'b1; break; end
      if (done_irq !== 1'b0) early++;
    end
    checks++; if (!ok || early != 0) begin errors++; $display("FAIL irq_early: idle=%b early=%0d want 1/0", ok, early); end
    checks++; if (done_irq !== 1'b1) begin errors++; $display("FAIL irq_rise: got %b want 1", done_irq); end
    repeat (5) @(posedge clk);
    #1;
    checks++; if (done_irq !== 1'b1) begin errors++; $display("FAIL irq_hold: got %b want 1", done_irq); end
    push(8'h77);
    checks++; if (done_irq !== 1'b0) begin errors++; $display("FAIL irq_clear: got %b want 0", done_irq); end
    wait_idle(400, t_end, ok);
    checks++; if (!ok || done_irq !== 1'b1) begin errors++; $display("FAIL irq_second: idle=%b irq=%b want 1/1", ok, done_irq); end
  endtask
`endif

  initial begin : main
    test_reset();
    test_single();
    test_burst();
    test_overflow();
    test_wrap();
    test_reset_mid();
`ifdef DEBUG_UART_DONE_IRQ_EN
    test_done_irq();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
